// File: rtl/fifo_read_scheduler.sv
// FIFO read scheduler: pulls samples from a FIFO and hands them to the
// UART path or one of two I2S rates, repeating the last sample on underrun.
module fifo_read_scheduler #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 1,
  parameter int DIV_44K    = 227,
  parameter int DIV_2H     = 5000000,
  localparam int W         = FRAME_SIZE * BPS
) (
  input  logic         in_clk,
  input  logic         in_reset,
  input  logic [1:0]   in_mode,
  input  logic         in_fifo_empty,
  input  logic [W-1:0] in_fifo_data,
  input  logic         in_uart_ready,
  output logic         out_fifo_rd_en,
  output logic [W-1:0] out_sample,
  output logic         out_uart_en,
  output logic         out_i2s2H_en,
  output logic         out_i2s441kH_en,
  output logic [7:0]   out_underrun_cnt,
  output logic         out_busy
);

  localparam int DMAX = (DIV_2H > DIV_44K) ? DIV_2H : DIV_44K;
  localparam int CW   = $clog2(DMAX);
  localparam logic [CW-1:0] TOP_44K = CW'(DIV_44K - 1);
  localparam logic [CW-1:0] TOP_2H  = CW'(DIV_2H - 1);

  localparam logic [1:0] M_UART = 2'b00;
  localparam logic [1:0] M_2H   = 2'b01;
  localparam logic [1:0] M_44K  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    ISSUE,
    WAIT_ACK
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   sample_q, sample_d;
  logic           rd_q, rd_d;
  logic           uart_q, uart_d;
  logic           i2h_q, i2h_d;
  logic           i44_q, i44_d;
  logic [7:0]     ucnt_q, ucnt_d;
  logic           busy_q, busy_d;
  logic           take_tick;
  logic           wrap;
  logic [CW-1:0]  tick_top;

  // Rate tick: counts only in I2S modes, restarts on any mode change.
  always_comb begin
    mode_d   = in_mode;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    wrap     = 1'b0;
    tick_top = TOP_44K;
    if (mode_q == M_2H) tick_top = TOP_2H;
    if (in_mode != mode_q) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (mode_q == M_2H || mode_q == M_44K) begin
      if (cnt_q == tick_top) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
    if (take_tick) pend_d = 1'b0;
    if (wrap) pend_d = 1'b1;
  end

  // Scheduler FSM; strobes are derived from the next state so they
  // appear registered in the cycle the FSM occupies that state.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sample_d  = sample_q;
    ucnt_d    = ucnt_q;
    take_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (in_mode)
          M_UART: begin
            if (in_uart_ready && !in_fifo_empty) begin
              op_d    = M_UART;
              state_d = READ;
            end
          end
          M_2H, M_44K: begin
            if (pend_q && in_mode == mode_q) begin
              take_tick = 1'b1;
              op_d      = in_mode;
              if (!in_fifo_empty) begin
                state_d = READ;
              end else begin
                state_d = ISSUE;
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
      READ:  state_d = LATCH;
      LATCH: begin
        sample_d = in_fifo_data;
        state_d  = ISSUE;
      end
      ISSUE: state_d = (op_q == M_UART) ? WAIT_ACK : IDLE;
      WAIT_ACK: begin
        if (!in_uart_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rd_d   = (state_d == READ);
    uart_d = (state_d == ISSUE) && (op_d == M_UART);
    i2h_d  = (state_d == ISSUE) && (op_d == M_2H);
    i44_d  = (state_d == ISSUE) && (op_d == M_44K);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= IDLE;
      mode_q   <= M_UART;
      op_q     <= M_UART;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      sample_q <= '0;
      rd_q     <= 1'b0;
      uart_q   <= 1'b0;
      i2h_q    <= 1'b0;
      i44_q    <= 1'b0;
      ucnt_q   <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      rd_q     <= rd_d;
      uart_q   <= uart_d;
      i2h_q    <= i2h_d;
      i44_q    <= i44_d;
      ucnt_q   <= ucnt_d;
      busy_q   <= busy_d;
    end
  end

  assign out_fifo_rd_en   = rd_q;
  assign out_sample       = sample_q;
  assign out_uart_en      = uart_q;
  assign out_i2s2H_en     = i2h_q;
  assign out_i2s441kH_en  = i44_q;
  assign out_underrun_cnt = ucnt_q;
  assign out_busy         = busy_q;

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: a FIFO/UART environment,
// a transaction-level reference model and a decoupled output monitor.
module tb_fifo_read_scheduler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   in_mode = 2'b00;
  logic         in_fifo_empty;
  logic [W-1:0] in_fifo_data = '0;
  logic         in_uart_ready = 1'b0;
  logic         out_fifo_rd_en;
  logic [W-1:0] out_sample;
  logic         out_uart_en;
  logic         out_i2s2H_en;
  logic         out_i2s441kH_en;
  logic [7:0]   out_underrun_cnt;
  logic         out_busy;

  fifo_read_scheduler #(
    .BPS(16), .FRAME_SIZE(1), .DIV_44K(8), .DIV_2H(16)
  ) dut (
    .in_clk(clk),
    .in_reset(rst),
    .in_mode(in_mode),
    .in_fifo_empty(in_fifo_empty),
    .in_fifo_data(in_fifo_data),
    .in_uart_ready(in_uart_ready),
    .out_fifo_rd_en(out_fifo_rd_en),
    .out_sample(out_sample),
    .out_uart_en(out_uart_en),
    .out_i2s2H_en(out_i2s2H_en),
    .out_i2s441kH_en(out_i2s441kH_en),
    .out_underrun_cnt(out_underrun_cnt),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input bit ok,
                     input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, req, req, cyc);
  endtask

  // Environment FIFO: data appears the cycle after rd_en.
  logic [W-1:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign in_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (out_fifo_rd_en && !in_fifo_empty) begin
      in_fifo_data <= fmem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // UART packer: goes busy for 1..3 cycles after each accepted sample.
  bit uart_on = 1'b0;
  initial begin
    int  hold;
    bit  saw;
    hold = 0;
    forever begin
      @(negedge clk);
      saw = out_uart_en;
      @(posedge clk);
      #1;
      if (saw) hold = $urandom_range(1, 3);
      if (hold > 0) begin
        in_uart_ready = 1'b0;
        hold--;
      end else begin
        in_uart_ready = uart_on && ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Reference model: each output event is a (path, sample, underrun
  // count, came-from-a-read) tuple, derived from the scheduling rules.
  typedef struct {
    int           kind;
    logic [W-1:0] smp;
    int           uc;
    bit           rd;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;
  int           m_ucnt = 0;
  int           exp_reads = 0;

  task automatic env_push(input logic [W-1:0] w);
    fmem[wr_ptr[9:0]] = w;
    wr_ptr++;
    mq.push_back(w);
  endtask

  task automatic model_serve(input int kind);
    exp_t e;
    e.kind = kind;
    if (mq.size() > 0) begin
      m_last = mq.pop_front();
      e.rd = 1'b1;
      exp_reads++;
    end else begin
      e.rd = 1'b0;
      if (m_ucnt < 255) m_ucnt++;
    end
    e.smp = m_last;
    e.uc  = m_ucnt;
    exp_q.push_back(e);
  endtask

  // Timing context for the I2S rate checks.
  int phase = 0;
  int period = 0;
  int chg_cyc = 0;

  // Monitor: pops the scoreboard whenever an enable strobe appears.
  int rd_cnt = 0;
  initial begin
    int   last_rd, prev_acc, mon_phase, acc, got, enc;
    bit   have_prev;
    exp_t e;
    last_rd = 0;
    prev_acc = 0;
    mon_phase = -1;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_fifo_rd_en) begin
          rd_cnt++;
          last_rd = cyc;
          chk("rd_nonempty", !in_fifo_empty, int'(in_fifo_empty), 0);
        end
        enc = {29'd0, out_i2s441kH_en, out_i2s2H_en, out_uart_en};
        if (enc != 0) begin
          got = (enc == 1) ? 0 : (enc == 2) ? 1 : (enc == 4) ? 2 : 9;
          if (exp_q.size() == 0) begin
            chk("unexpected_en", 1'b0, enc, 0);
          end else begin
            e = exp_q.pop_front();
            chk("en_kind", got == e.kind, got, e.kind);
            chk("sample", out_sample == e.smp, int'(out_sample), int'(e.smp));
            chk("underrun_cnt", int'(out_underrun_cnt) == e.uc,
                int'(out_underrun_cnt), e.uc);
            chk("busy_at_en", out_busy, int'(out_busy), 1);
            if (e.rd) chk("rd_to_en", cyc - last_rd == 2, cyc - last_rd, 2);
            if (e.kind != 0) begin
              acc = cyc - (e.rd ? 3 : 1);
              if (phase != mon_phase) begin
                mon_phase = phase;
                have_prev = 1'b0;
              end
              if (!have_prev)
                chk("first_tick", acc - chg_cyc == period + 1,
                    acc - chg_cyc, period + 1);
              else
                chk("tick_period", acc - prev_acc == period,
                    acc - prev_acc, period);
              prev_acc = acc;
              have_prev = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm, input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step(1);
      k++;
    end
    chk(nm, exp_q.size() == 0, exp_q.size(), 0);
  endtask

  task automatic wait_rd(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_fifo_rd_en && k < 100);
    chk(nm, out_fifo_rd_en, int'(out_fifo_rd_en), 1);
  endtask

  initial begin
    logic [W-1:0] w;
    int           n, n_rd, n_en;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", !out_fifo_rd_en, int'(out_fifo_rd_en), 0);
    chk("rst_sample", out_sample == '0, int'(out_sample), 0);
    chk("rst_en", !(out_uart_en | out_i2s2H_en | out_i2s441kH_en),
        int'({out_i2s441kH_en, out_i2s2H_en, out_uart_en}), 0);
    chk("rst_ucnt", out_underrun_cnt == 8'd0, int'(out_underrun_cnt), 0);
    chk("rst_busy", !out_busy, int'(out_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // UART path with random data and random packer back-pressure.
    uart_on = 1'b1;
    env_push(16'hA5A5);
    model_serve(0);
    for (int i = 0; i < 20; i++) begin
      w = W'($urandom);
      env_push(w);
      model_serve(0);
      step($urandom_range(0, 6));
    end
    drain("drain_uart", 2000);
    uart_on = 1'b0;
    step(6);

    // 44.1 kHz: ordered samples, then underrun repeats and saturation.
    env_push(16'h0001);
    env_push(16'h0002);
    env_push(16'h0003);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) env_push(W'($urandom));
    env_push(16'h1234);
    phase = 2;
    period = 8;
    chg_cyc = cyc;
    in_mode = 2'b10;
    for (int i = 0; i < n + 4 + 300; i++) model_serve(2);
    drain("drain_44k", 4000);
    in_mode = 2'b11;
    step(4);

    // Mode switch 00 -> 01 while a UART read sits in LATCH.
    uart_on = 1'b1;
    in_mode = 2'b00;
    w = W'($urandom);
    env_push(w);
    model_serve(0);
    wait_rd("rd_before_switch");
    @(posedge clk);
    #1;
    phase = 3;
    period = 16;
    chg_cyc = cyc;
    in_mode = 2'b01;
    for (int i = 0; i < 4; i++) model_serve(1);
    drain("drain_2h", 300);
    in_mode = 2'b11;
    step(4);

    // Reset while in READ, then halt mode must stay silent.
    in_mode = 2'b00;
    fmem[wr_ptr[9:0]] = W'($urandom);
    wr_ptr++;
    exp_reads++;
    wait_rd("rd_before_reset");
    #1;
    rst = 1'b1;
    in_mode = 2'b11;
    m_ucnt = 0;
    m_last = '0;
    #1;
    chk("midrst_rd_en", !out_fifo_rd_en, int'(out_fifo_rd_en), 0);
    chk("midrst_sample", out_sample == '0, int'(out_sample), 0);
    chk("midrst_en", !(out_uart_en | out_i2s2H_en | out_i2s441kH_en),
        int'({out_i2s441kH_en, out_i2s2H_en, out_uart_en}), 0);
    chk("midrst_ucnt", out_underrun_cnt == 8'd0, int'(out_underrun_cnt), 0);
    chk("midrst_busy", !out_busy, int'(out_busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_rd = 0;
    n_en = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_fifo_rd_en) n_rd++;
      if (out_uart_en | out_i2s2H_en | out_i2s441kH_en) n_en++;
    end
    chk("halt_rd", n_rd == 0, n_rd, 0);
    chk("halt_en", n_en == 0, n_en, 0);
    chk("halt_busy", !out_busy, int'(out_busy), 0);
    chk("total_reads", rd_cnt == exp_reads, rd_cnt, exp_reads);
    chk("sb_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
